// File: rtl/z80fi_seq_check_pkg.sv
// z80fi_pkg: shared definitions for the Z80FI sequence checker.
//   REGS_W and field LSB offsets of the packed register state
//   {A,B,C,D,E,H,L,F,I,R,IX,IY,SP,IP,IFF1,IFF2} (A at the MSB end),
//   err bit indices, the shadow-memory slot record and the continuity mask helper.
package z80fi_pkg;

  localparam int REGS_W   = 146;

  localparam int IFF2_LSB = 0;
  localparam int IFF1_LSB = 1;
  localparam int IP_LSB   = 2;
  localparam int SP_LSB   = 18;
  localparam int IY_LSB   = 34;
  localparam int IX_LSB   = 50;
  localparam int R_LSB    = 66;
  localparam int I_LSB    = 74;
  localparam int F_LSB    = 82;
  localparam int L_LSB    = 90;
  localparam int H_LSB    = 98;
  localparam int E_LSB    = 106;
  localparam int D_LSB    = 114;
  localparam int C_LSB    = 122;
  localparam int B_LSB    = 130;
  localparam int A_LSB    = 138;

  localparam int ERR_W     = 4;
  localparam int ERR_CONT  = 0;
  localparam int ERR_RAW   = 1;
  localparam int ERR_PROTO = 2;
  localparam int ERR_OVF   = 3;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [7:0]  data;
  } shadow_slot_t;

  // Bits that take part in the regs_in/prev_out comparison. R is a free-running
  // refresh counter, so it is normally left out.
  function automatic logic [REGS_W-1:0] cont_mask(input bit check_r);
    logic [REGS_W-1:0] m;
    m = '1;
    if (!check_r) m[R_LSB +: 8] = 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/z80fi_seq_check_if.sv
// z80fi_seq_check_if: one retirement record of the Z80FI stream.
//   valid                retirement strobe
//   regs_in / regs_out   packed pre/post register state
//   mem_rd/raddr/rdata   two read ports, [0]=rd, [1]=rd2
//   mem_wr/waddr/wdata   two write ports, [0]=wr, [1]=wr2
// master = the core/formal harness producing retirements, slave = checkers.
interface z80fi_seq_check_if;
  import z80fi_pkg::*;

  logic                   valid;
  logic [REGS_W-1:0]      regs_in;
  logic [REGS_W-1:0]      regs_out;
  logic [1:0]             mem_rd;
  logic [1:0][15:0]       mem_raddr;
  logic [1:0][7:0]        mem_rdata;
  logic [1:0]             mem_wr;
  logic [1:0][15:0]       mem_waddr;
  logic [1:0][7:0]        mem_wdata;

  modport master (
    output valid, regs_in, regs_out,
    output mem_rd, mem_raddr, mem_rdata,
    output mem_wr, mem_waddr, mem_wdata
  );

  modport slave (
    input valid, regs_in, regs_out,
    input mem_rd, mem_raddr, mem_rdata,
    input mem_wr, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/z80fi_seq_check_shadow_mem.sv
// z80fi_shadow_mem: small fully associative shadow of bytes written by retired
// instructions.
//   clk, reset          clock / synchronous active-low reset (all slots invalid)
//   upd                 apply this cycle's writes (retirement strobe)
//   raddr[2]            lookup addresses; rhit/hit_data reflect the state
//                       before this cycle's writes
//   wr/waddr/wdata[2]   write ports, applied port 0 then port 1
//   ovf                 pulse: a write found no free slot and evicted the slot
//                       at the round-robin pointer
module z80fi_shadow_mem
  import z80fi_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            upd,
  input  logic [1:0][15:0] raddr,
  output logic [1:0]      rhit,
  output logic [1:0][7:0] hit_data,
  input  logic [1:0]      wr,
  input  logic [1:0][15:0] waddr,
  input  logic [1:0][7:0] wdata,
  output logic            ovf
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  shadow_slot_t     slots [NUM_SLOTS];
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] rr_mid;
  logic [IDX_W-1:0] rr_next;

  logic             hit0, free0, hit1, free1;
  logic [IDX_W-1:0] hidx0, fidx0, hidx1, fidx1;
  logic [IDX_W-1:0] idx0, idx1;
  logic             ovf0, ovf1, same_addr;

  function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(NUM_SLOTS - 1)) return '0;
    return v + IDX_W'(1);
  endfunction

  always_comb begin
    rhit     = '0;
    hit_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slots[i].valid && (slots[i].addr == raddr[p])) begin
          rhit[p]     = 1'b1;
          hit_data[p] = slots[i].data;
        end
      end
    end
  end

  // Slot selection. Searches run from the top index down so the lowest matching
  // slot wins. Port 1 sees the table as port 0 leaves it: the slot port 0 is
  // about to write now holds waddr[0], so it is neither free nor a hit for a
  // different port-1 address.
  always_comb begin
    hit0  = 1'b0;
    hidx0 = '0;
    free0 = 1'b0;
    fidx0 = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots[i].valid && (slots[i].addr == waddr[0])) begin
        hit0  = 1'b1;
        hidx0 = IDX_W'(i);
      end
      if (!slots[i].valid) begin
        free0 = 1'b1;
        fidx0 = IDX_W'(i);
      end
    end
    ovf0   = wr[0] && !hit0 && !free0;
    idx0   = hit0 ? hidx0 : (free0 ? fidx0 : rr);
    rr_mid = ovf0 ? rr_inc(rr) : rr;

    same_addr = wr[0] && (waddr[1] == waddr[0]);
    hit1  = 1'b0;
    hidx1 = '0;
    free1 = 1'b0;
    fidx1 = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!(wr[0] && (IDX_W'(i) == idx0))) begin
        if (slots[i].valid && (slots[i].addr == waddr[1])) begin
          hit1  = 1'b1;
          hidx1 = IDX_W'(i);
        end
        if (!slots[i].valid) begin
          free1 = 1'b1;
          fidx1 = IDX_W'(i);
        end
      end
    end
    ovf1    = wr[1] && !same_addr && !hit1 && !free1;
    idx1    = same_addr ? idx0 : (hit1 ? hidx1 : (free1 ? fidx1 : rr_mid));
    rr_next = ovf1 ? rr_inc(rr_mid) : rr_mid;
    ovf     = upd && (ovf0 || ovf1);
  end

  // Port 1 is written last so it wins whenever both ports land in one slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      rr <= '0;
    end else if (upd) begin
      if (wr[0]) slots[idx0] <= '{valid: 1'b1, addr: waddr[0], data: wdata[0]};
      if (wr[1]) slots[idx1] <= '{valid: 1'b1, addr: waddr[1], data: wdata[1]};
      rr <= rr_next;
    end
  end

endmodule

// File: rtl/z80fi_seq_check.sv
// z80fi_seq_check: multi-instruction checker on the Z80FI retirement stream.
// Checks register continuity between consecutive retirements and memory
// read-after-write consistency against a shadow memory.
//   clk, reset     clock / synchronous active-low reset
//   bus (slave)    retirement record, see z80fi_seq_check_if
//   insn_count     retired instructions since reset, saturating
//   in_window      insn_count lies inside [WIN_START, WIN_START+WIN_LEN)
//   err            sticky: [0] continuity, [1] RAW mismatch, [2] strobe
//                  protocol, [3] shadow overflow
module z80fi_seq_check
  import z80fi_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int WIN_START = 0,
  parameter int WIN_LEN   = 8,
  parameter bit CHECK_R   = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  z80fi_seq_check_if.slave bus,
  output logic [CNT_W-1:0] insn_count,
  output logic             in_window,
  output logic [ERR_W-1:0] err
);

  localparam logic [REGS_W-1:0] CMP_MASK = cont_mask(CHECK_R);

  logic [REGS_W-1:0] prev_out;
  logic              have_prev;
  logic [31:0]       count_ext;
  logic              lo_ok, hi_ok;
  logic [1:0]        rhit;
  logic [1:0][7:0]   shadow_data;
  logic              ovf;
  logic [ERR_W-1:0]  err_now;

  assign count_ext = 32'(insn_count);

  // Open bounds are elaborated away so no comparison against zero remains.
  if (WIN_START == 0) begin : g_lo_open
    assign lo_ok = 1'b1;
  end else begin : g_lo
    assign lo_ok = (count_ext >= 32'(WIN_START));
  end

  if (WIN_LEN == 0) begin : g_hi_open
    assign hi_ok = 1'b1;
  end else begin : g_hi
    assign hi_ok = (count_ext < 32'(WIN_START + WIN_LEN));
  end

  assign in_window = lo_ok && hi_ok;

  z80fi_shadow_mem #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .upd      (bus.valid),
    .raddr    (bus.mem_raddr),
    .rhit     (rhit),
    .hit_data (shadow_data),
    .wr       (bus.mem_wr),
    .waddr    (bus.mem_waddr),
    .wdata    (bus.mem_wdata),
    .ovf      (ovf)
  );

  // Reads compare against the shadow as it stood before this instruction's
  // writes; a shadow miss means nothing is known about that byte.
  always_comb begin
    err_now = '0;
    err_now[ERR_CONT] = have_prev && in_window &&
                        (((bus.regs_in ^ prev_out) & CMP_MASK) != '0);
    for (int p = 0; p < 2; p++) begin
      if (in_window && bus.mem_rd[p] && rhit[p] &&
          (shadow_data[p] != bus.mem_rdata[p])) begin
        err_now[ERR_RAW] = 1'b1;
      end
    end
    err_now[ERR_PROTO] = (bus.mem_rd[1] && !bus.mem_rd[0]) ||
                         (bus.mem_wr[1] && !bus.mem_wr[0]);
    err_now[ERR_OVF]   = ovf;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      insn_count <= '0;
      have_prev  <= 1'b0;
      prev_out   <= '0;
      err        <= '0;
    end else if (bus.valid) begin
      if (insn_count != {CNT_W{1'b1}}) insn_count <= insn_count + CNT_W'(1);
      have_prev <= 1'b1;
      prev_out  <= bus.regs_out;
      err       <= err | err_now;
    end
  end

`ifdef FORMAL
  always_ff @(posedge clk) begin
    if (reset) assert (err == '0);
    cover (bus.valid && in_window && have_prev);
  end
`endif

endmodule

// File: tb/tb_z80fi_seq_check.sv
module tb_z80fi_seq_check;
  import z80fi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  z80fi_seq_check_if bus ();

  logic [7:0] cnt_a; logic win_a; logic [3:0] err_a;
  logic [7:0] cnt_w; logic win_w; logic [3:0] err_w;
  logic [1:0] cnt_s; logic win_s; logic [3:0] err_s;

  // a: default window 0..7, R masked
  z80fi_seq_check #(.NUM_SLOTS(4), .WIN_START(0), .WIN_LEN(8), .CHECK_R(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus), .insn_count(cnt_a), .in_window(win_a), .err(err_a));
  // w: window covers only instruction index 2
  z80fi_seq_check #(.NUM_SLOTS(4), .WIN_START(2), .WIN_LEN(1), .CHECK_R(1'b0), .CNT_W(8)) dut_w (
    .clk(clk), .reset(reset), .bus(bus), .insn_count(cnt_w), .in_window(win_w), .err(err_w));
  // s: 2-bit saturating counter, window 0..2, R compared
  z80fi_seq_check #(.NUM_SLOTS(4), .WIN_START(0), .WIN_LEN(3), .CHECK_R(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bus), .insn_count(cnt_s), .in_window(win_s), .err(err_s));

  int errors = 0;
  int checks = 0;
  logic [REGS_W-1:0] last_out;

  function automatic logic [REGS_W-1:0] rand_regs();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[REGS_W-1:0];
  endfunction

  task automatic idle_bus();
    bus.valid = 1'b0; bus.regs_in = '0; bus.regs_out = '0;
    bus.mem_rd = '0; bus.mem_raddr = '0; bus.mem_rdata = '0;
    bus.mem_wr = '0; bus.mem_waddr = '0; bus.mem_wdata = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    last_out = rand_regs();
  endtask

  task automatic set_wr(input int p, input logic [15:0] a, input logic [7:0] d);
    bus.mem_wr[p] = 1'b1; bus.mem_waddr[p] = a; bus.mem_wdata[p] = d;
  endtask

  task automatic set_rd(input int p, input logic [15:0] a, input logic [7:0] d);
    bus.mem_rd[p] = 1'b1; bus.mem_raddr[p] = a; bus.mem_rdata[p] = d;
  endtask

  // Retire one instruction with memory strobes already set; brk corrupts A in regs_in.
  task automatic retire(input logic brk);
    logic [REGS_W-1:0] ro;
    ro = rand_regs();
    bus.regs_in = last_out;
    if (brk) bus.regs_in[A_LSB +: 8] = ~last_out[A_LSB +: 8];
    bus.regs_out = ro;
    bus.valid = 1'b1;
    @(posedge clk); #1;
    last_out = ro;
    idle_bus();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", cnt_a); end
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL reset_err actual=%b required=0000", err_a); end
    checks++; if (win_a !== 1'b1) begin errors++; $display("FAIL reset_win_a actual=%b required=1", win_a); end
    checks++; if (win_w !== 1'b0) begin errors++; $display("FAIL reset_win_w actual=%b required=0", win_w); end
    checks++; if (cnt_s !== 2'd0) begin errors++; $display("FAIL reset_count_s actual=%0d required=0", cnt_s); end
  endtask

  task automatic test_continuity();
    logic [REGS_W-1:0] junk;
    do_reset();
    for (int i = 0; i < 3; i++) retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL cont_err actual=%b required=0000", err_a); end
    checks++; if (cnt_a !== 8'd3) begin errors++; $display("FAIL cont_count actual=%0d required=3", cnt_a); end
    checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL cont_count_s actual=%0d required=3", cnt_s); end
    checks++; if (win_s !== 1'b0) begin errors++; $display("FAIL cont_win_s actual=%b required=0", win_s); end
    // idle cycles carrying garbage must not touch any state
    junk = rand_regs();
    bus.regs_in = ~last_out; bus.regs_out = junk;
    set_wr(1, 16'h2000, 8'h01); set_rd(1, 16'h2000, 8'h02);
    repeat (3) @(posedge clk);
    #1; idle_bus();
    checks++; if (cnt_a !== 8'd3) begin errors++; $display("FAIL idle_count actual=%0d required=3", cnt_a); end
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL idle_err actual=%b required=0000", err_a); end
    retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL idle_prev_kept actual=%b required=0000", err_a); end
  endtask

  task automatic test_cont_break();
    logic [REGS_W-1:0] r0, r1;
    do_reset();
    r0 = rand_regs(); r0[A_LSB +: 8] = 8'h12;
    bus.regs_in = rand_regs(); bus.regs_out = r0; bus.valid = 1'b1;
    @(posedge clk); #1; idle_bus();
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL brk_first actual=%b required=0000", err_a); end
    r1 = r0; r1[A_LSB +: 8] = 8'h13;
    last_out = rand_regs();
    bus.regs_in = r1; bus.regs_out = last_out; bus.valid = 1'b1;
    @(posedge clk); #1; idle_bus();
    checks++; if (err_a !== 4'b0001) begin errors++; $display("FAIL brk_set actual=%b required=0001", err_a); end
    retire(1'b0); retire(1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_a !== 4'b0001) begin errors++; $display("FAIL brk_sticky actual=%b required=0001", err_a); end
  endtask

  task automatic test_r_mask();
    do_reset();
    retire(1'b0);
    bus.regs_in = last_out;
    bus.regs_in[R_LSB +: 8] = last_out[R_LSB +: 8] ^ 8'h01;
    last_out = rand_regs();
    bus.regs_out = last_out; bus.valid = 1'b1;
    @(posedge clk); #1; idle_bus();
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL rmask_masked actual=%b required=0000", err_a); end
    checks++; if (err_s !== 4'b0001) begin errors++; $display("FAIL rmask_checked actual=%b required=0001", err_s); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    retire(1'b0); retire(1'b1);
    checks++; if (err_a !== 4'b0001) begin errors++; $display("FAIL midrst_pre actual=%b required=0001", err_a); end
    do_reset();
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL midrst_err actual=%b required=0000", err_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL midrst_count actual=%0d required=0", cnt_a); end
    retire(1'b1);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL midrst_first actual=%b required=0000", err_a); end
  endtask

  task automatic test_raw();
    do_reset();
    set_wr(0, 16'h4000, 8'hAA); retire(1'b0);
    set_rd(0, 16'h4000, 8'hAB); retire(1'b0);
    checks++; if (err_a !== 4'b0010) begin errors++; $display("FAIL raw_bad actual=%b required=0010", err_a); end
    do_reset();
    set_wr(0, 16'h4000, 8'hAA); retire(1'b0);
    set_rd(0, 16'h4000, 8'hAA); retire(1'b0);
    set_rd(0, 16'h7777, 8'h00); set_rd(1, 16'h4000, 8'hAA); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL raw_good actual=%b required=0000", err_a); end
    set_rd(0, 16'h7777, 8'h00); set_rd(1, 16'h4000, 8'h3C); retire(1'b0);
    checks++; if (err_a !== 4'b0010) begin errors++; $display("FAIL raw_port1 actual=%b required=0010", err_a); end
  endtask

  task automatic test_same_insn();
    do_reset();
    set_wr(0, 16'h4000, 8'h11); retire(1'b0);
    set_rd(0, 16'h4000, 8'h11); set_wr(0, 16'h4000, 8'h55); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL same_old actual=%b required=0000", err_a); end
    set_rd(0, 16'h4000, 8'h55); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL same_new actual=%b required=0000", err_a); end
    set_rd(0, 16'h4000, 8'h11); retire(1'b0);
    checks++; if (err_a !== 4'b0010) begin errors++; $display("FAIL same_stale actual=%b required=0010", err_a); end
  endtask

  task automatic test_dual_write();
    do_reset();
    set_wr(0, 16'h5000, 8'h01); set_wr(1, 16'h5000, 8'h02); retire(1'b0);
    set_rd(0, 16'h5000, 8'h02); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL dual_same_wr2 actual=%b required=0000", err_a); end
    set_wr(0, 16'h5001, 8'hA1); set_wr(1, 16'h5002, 8'hA2); retire(1'b0);
    set_wr(0, 16'h5003, 8'hA3); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL dual_one_slot actual=%b required=0000", err_a); end
    set_rd(0, 16'h5000, 8'h01); retire(1'b0);
    checks++; if (err_a !== 4'b0010) begin errors++; $display("FAIL dual_same_old actual=%b required=0010", err_a); end
    do_reset();
    set_wr(0, 16'h6000, 8'h60); set_wr(1, 16'h6001, 8'h61); retire(1'b0);
    set_rd(0, 16'h6000, 8'h60); set_rd(1, 16'h6001, 8'h61); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL dual_diff_good actual=%b required=0000", err_a); end
    set_rd(0, 16'h6000, 8'h99); retire(1'b0);
    checks++; if (err_a !== 4'b0010) begin errors++; $display("FAIL dual_diff_kept actual=%b required=0010", err_a); end
  endtask

  task automatic test_protocol();
    do_reset();
    set_rd(0, 16'h1234, 8'h00); set_rd(1, 16'h1235, 8'h00); retire(1'b0);
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL proto_ok actual=%b required=0000", err_a); end
    set_rd(1, 16'h1235, 8'h00); retire(1'b0);
    checks++; if (err_a !== 4'b0100) begin errors++; $display("FAIL proto_rd2 actual=%b required=0100", err_a); end
    do_reset();
    set_wr(1, 16'h1236, 8'h00); retire(1'b0);
    checks++; if (err_a !== 4'b0100) begin errors++; $display("FAIL proto_wr2 actual=%b required=0100", err_a); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_wr(0, 16'h1000 + 16'(i), 8'h10 + 8'(i)); retire(1'b0);
    end
    checks++; if (err_a !== 4'b0000) begin errors++; $display("FAIL ovf_full actual=%b required=0000", err_a); end
    set_wr(0, 16'h1004, 8'h14); retire(1'b0);
    checks++; if (err_a !== 4'b1000) begin errors++; $display("FAIL ovf_set actual=%b required=1000", err_a); end
    set_rd(0, 16'h1000, 8'hEE); retire(1'b0);
    checks++; if (err_a !== 4'b1000) begin errors++; $display("FAIL ovf_evicted actual=%b required=1000", err_a); end
    set_rd(0, 16'h1001, 8'hEE); retire(1'b0);
    checks++; if (err_a !== 4'b1010) begin errors++; $display("FAIL ovf_kept actual=%b required=1010", err_a); end
  endtask

  task automatic test_window();
    do_reset();
    retire(1'b0); retire(1'b1);
    checks++; if (err_w !== 4'b0000) begin errors++; $display("FAIL win_brk1 actual=%b required=0000", err_w); end
    checks++; if (err_a !== 4'b0001) begin errors++; $display("FAIL win_brk1_a actual=%b required=0001", err_a); end
    checks++; if (win_w !== 1'b1) begin errors++; $display("FAIL win_in actual=%b required=1", win_w); end
    retire(1'b1);
    checks++; if (err_w !== 4'b0001) begin errors++; $display("FAIL win_brk2 actual=%b required=0001", err_w); end
    checks++; if (win_w !== 1'b0) begin errors++; $display("FAIL win_out actual=%b required=0", win_w); end
    do_reset();
    retire(1'b0); retire(1'b0); retire(1'b0); retire(1'b1);
    checks++; if (err_w !== 4'b0000) begin errors++; $display("FAIL win_brk3 actual=%b required=0000", err_w); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) retire(1'b0);
    checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL sat_hold actual=%0d required=3", cnt_s); end
    retire(1'b1);
    checks++; if (cnt_s !== 2'd3) begin errors++; $display("FAIL sat_count actual=%0d required=3", cnt_s); end
    checks++; if (err_s !== 4'b0000) begin errors++; $display("FAIL sat_outside actual=%b required=0000", err_s); end
    checks++; if (cnt_a !== 8'd5) begin errors++; $display("FAIL sat_count_a actual=%0d required=5", cnt_a); end
    checks++; if (err_a !== 4'b0001) begin errors++; $display("FAIL sat_err_a actual=%b required=0001", err_a); end
  endtask

  initial begin
    idle_bus();
    last_out = '0;
    test_reset();
    test_continuity();
    test_cont_break();
    test_r_mask();
    test_mid_reset();
    test_raw();
    test_same_insn();
    test_dual_write();
    test_protocol();
    test_overflow();
    test_window();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
